uart_tx_periph: RTL

//  Memory-mapped UART transmitter that responds to LSU store/load traffic routed by uart_sel.
//  - CPU writes bytes into an 8-deep TX FIFO.
//  - An FSM serialises each byte 8N1, LSB first, onto the tx line.
//  - CPU reads a status register to poll for FIFO space and idle.

---
 rtl/uart_tx_periph_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_tx_periph.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the transmit FSM state encoding.
package uart_tx_periph_pkg;

  localparam logic [31:0] UART_BASE_ADDRESS = 32'h1000_0000;

  // Register offsets, as decoded from addr[3:2]
  localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
  localparam logic [1:0] UART_STATUS_OFF = 2'd1;
  localparam logic [1:0] UART_BAUD_OFF   = 2'd2;

  // STATUS register bit indices
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_EMPTY_BIT  = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_PARITY_BIT = 4;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry one extra
// wrap bit so full/empty are derived without a separate occupancy counter.
// The caller must not push when full (unless popping the same cycle) and
// must not pop when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Advance write/read pointers on push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array write
  // NOTE: the array has no reset; entries are only ever read after being written, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the memory-stage bus.
// CPU stores to TXDATA fill an 8-deep FIFO; the FSM serialises bytes LSB
// first. STATUS reports busy/full/empty/overflow; BAUDDIV sets clk cycles
// per bit and is sampled once per frame.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits and sets STATUS[4].
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 868,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_sel,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_irq
);

  localparam logic [2:0] S_IDLE   = UART_TX_IDLE;
  localparam logic [2:0] S_START  = UART_TX_START;
  localparam logic [2:0] S_DATA   = UART_TX_DATA;
  localparam logic [2:0] S_STOP   = UART_TX_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = UART_TX_PARITY;
  localparam logic       PARITY_PRESENT = 1'b1;
`else
  localparam logic       PARITY_PRESENT = 1'b0;
`endif

  logic [1:0]       reg_off;
  logic             wr_stb;
  logic             push_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             ovf;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] wr_div;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_sh;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             bit_done;
  logic             busy;
`ifdef UART_TX_PARITY_EN
  logic             par_bit;
`endif

  logic             unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:DIV_W]};

  assign reg_off  = addr[3:2];
  assign wr_stb   = uart_sel && wr_en;
  assign push_req = wr_stb && (reg_off == UART_TXDATA_OFF);
  assign wr_div   = (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];

  assign busy     = (state != S_IDLE);
  assign bit_done = (baud_cnt == '0);

  // A new byte is taken when idle, or on the last STOP cycle so frames run back-to-back.
  assign fifo_pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register writes: sticky overflow flag and baud divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      baud_div <= DIV_W'(BAUD_DIV_RST);
    end else begin
      if (wr_stb && (reg_off == UART_STATUS_OFF)) begin
        ovf <= 1'b0;
      end else if (push_req && !fifo_push) begin
        ovf <= 1'b1;
      end
      if (wr_stb && (reg_off == UART_BAUD_OFF)) baud_div <= wr_div;
    end
  end

  // Transmit FSM with per-bit baud counter; divisor is latched once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_sh   <= DIV_W'(1);
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (fifo_pop) begin
      state    <= S_START;
      shift    <= fifo_dout;
      div_sh   <= baud_div;
      baud_cnt <= baud_div - 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit  <= ^fifo_dout;
`endif
    end else begin
      case (state)
        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            bit_cnt  <= '0;
            baud_cnt <= div_sh - 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            shift    <= shift >> 1;
            baud_cnt <= div_sh - 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            baud_cnt <= div_sh - 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) state <= S_IDLE;
          else          baud_cnt <= baud_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Serial line level from the current FSM state
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves tx unassigned (no latch).
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = par_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign tx_irq = fifo_empty && !busy;

  // Load data mux, combinational from addr
  always_comb begin
    rdata = '0;
    case (reg_off)
      UART_STATUS_OFF: begin
        rdata[STAT_BUSY_BIT]   = busy;
        rdata[STAT_FULL_BIT]   = fifo_full;
        rdata[STAT_EMPTY_BIT]  = fifo_empty;
        rdata[STAT_OVF_BIT]    = ovf;
        rdata[STAT_PARITY_BIT] = PARITY_PRESENT;
      end
      UART_BAUD_OFF: rdata = 32'(baud_div);
      default:       rdata = '0;
    endcase
  end

endmodule
